// File: rtl/cat_pkg.sv
// Shared definitions for the cat stream filter: attribute bit map, reset
// mask defaults and the match rule used by both the RTL and its model.
package cat_pkg;

  localparam int ATTR_BLACK      = 0;
  localparam int ATTR_RED        = 1;
  localparam int ATTR_STERILIZED = 2;
  localparam int ATTR_MALE       = 3;

  // Widest attribute vector the shared match function accepts.
  localparam int ATTR_MAX_W = 16;

  localparam logic [3:0] DEF_MUST_SET = 4'(1 << ATTR_STERILIZED);
  localparam logic [3:0] DEF_MUST_CLR = 4'(1 << ATTR_MALE);
  localparam logic [3:0] DEF_ANY_OF   = 4'((1 << ATTR_BLACK) | (1 << ATTR_RED));

  // Callers zero-extend narrower vectors; unused upper bits never affect the result.
  function automatic logic cat_match(input logic [ATTR_MAX_W-1:0] attr,
                                     input logic [ATTR_MAX_W-1:0] must_set,
                                     input logic [ATTR_MAX_W-1:0] must_clr,
                                     input logic [ATTR_MAX_W-1:0] any_of);
    return ((attr & must_set) == must_set) &&
           ((attr & must_clr) == '0) &&
           ((any_of == '0) || (|(attr & any_of)));
  endfunction

endpackage

// File: rtl/cat_id_fifo.sv
// Synchronous FIFO with separate wrap-around pointers and an occupancy count;
// the head word is shown combinationally and reads as zero when empty.
module cat_id_fifo
  import cat_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is not reset; emptiness is tracked by count_q and dout is masked when empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cat_stream_filter.sv
// Streaming cat selector: accepts records, tests them against programmable
// masks, queues matching IDs and keeps saturating seen/match statistics.
module cat_stream_filter
  import cat_pkg::*;
#(
  parameter int                ATTR_W       = 4,
  parameter int                ID_W         = 8,
  parameter int                DEPTH        = 4,
  parameter int                CNT_W        = 16,
  parameter logic [ATTR_W-1:0] RST_MUST_SET = ATTR_W'(DEF_MUST_SET),
  parameter logic [ATTR_W-1:0] RST_MUST_CLR = ATTR_W'(DEF_MUST_CLR),
  parameter logic [ATTR_W-1:0] RST_ANY_OF   = ATTR_W'(DEF_ANY_OF)
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ID_W-1:0]   InId,
  input  logic [ATTR_W-1:0] InAttr,
  input  logic              CfgLoad,
  input  logic [ATTR_W-1:0] CfgMustSet,
  input  logic [ATTR_W-1:0] CfgMustClr,
  input  logic [ATTR_W-1:0] CfgAnyOf,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ID_W-1:0]   OutId,
  input  logic              ClearStats,
  output logic [CNT_W-1:0]  SeenCount,
  output logic [CNT_W-1:0]  MatchCount
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [ATTR_W-1:0] must_set_q, must_set_d;
  logic [ATTR_W-1:0] must_clr_q, must_clr_d;
  logic [ATTR_W-1:0] any_of_q, any_of_d;
  logic [CNT_W-1:0]  seen_q, seen_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic              accept, rec_match, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [PTR_W:0]    fifo_count;

  // Ready depends only on registered occupancy, never on OutReady.
  assign InReady   = (fifo_count < DEPTH_C);
  assign accept    = InValid && InReady;
  assign rec_match = cat_match(ATTR_MAX_W'(InAttr), ATTR_MAX_W'(must_set_q),
                               ATTR_MAX_W'(must_clr_q), ATTR_MAX_W'(any_of_q));
  assign fifo_push = accept && rec_match;
  assign OutValid  = !fifo_empty;
  assign fifo_pop  = OutValid && OutReady;

  // New masks take effect from the next edge, so a record in the load cycle sees the old ones.
  always_comb begin
    must_set_d = must_set_q;
    must_clr_d = must_clr_q;
    any_of_d   = any_of_q;
    if (CfgLoad) begin
      must_set_d = CfgMustSet;
      must_clr_d = CfgMustClr;
      any_of_d   = CfgAnyOf;
    end
  end

  always_comb begin
    seen_d  = seen_q;
    match_d = match_q;
    if (ClearStats) begin
      seen_d  = '0;
      match_d = '0;
    end else if (accept) begin
      if (seen_q != CNT_MAX) seen_d = seen_q + CNT_ONE;
      if (rec_match && (match_q != CNT_MAX)) match_d = match_q + CNT_ONE;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      must_set_q <= RST_MUST_SET;
      must_clr_q <= RST_MUST_CLR;
      any_of_q   <= RST_ANY_OF;
      seen_q     <= '0;
      match_q    <= '0;
    end else begin
      must_set_q <= must_set_d;
      must_clr_q <= must_clr_d;
      any_of_q   <= any_of_d;
      seen_q     <= seen_d;
      match_q    <= match_d;
    end
  end

  assign SeenCount  = seen_q;
  assign MatchCount = match_q;

  cat_id_fifo #(
    .DATA_W (ID_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (ResetN),
    .push  (fifo_push),
    .din   (InId),
    .pop   (fifo_pop),
    .dout  (OutId),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  full_flag_consistent : assert property (@(posedge Clk) disable iff (!ResetN)
    fifo_full == (fifo_count == DEPTH_C));

endmodule

// File: tb/tb_cat_stream_filter.sv
// Scoreboard bench for cat_stream_filter: a negedge monitor models masks,
// FIFO contents and counters, and compares every cycle.
module tb_cat_stream_filter;
  import cat_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = 7;

  logic       Clk = 1'b0;
  logic       ResetN;
  logic       InValid, InReady;
  logic [7:0] InId;
  logic [3:0] InAttr;
  logic       CfgLoad;
  logic [3:0] CfgMustSet, CfgMustClr, CfgAnyOf;
  logic       OutValid, OutReady;
  logic [7:0] OutId;
  logic       ClearStats;
  logic [CNT_W-1:0] SeenCount, MatchCount;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_q[$];
  int out_log[$];
  int exp_log[$];
  int m_seen, m_match;
  logic [3:0] m_set, m_clr, m_any;

  cat_stream_filter #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .InValid    (InValid),
    .InReady    (InReady),
    .InId       (InId),
    .InAttr     (InAttr),
    .CfgLoad    (CfgLoad),
    .CfgMustSet (CfgMustSet),
    .CfgMustClr (CfgMustClr),
    .CfgAnyOf   (CfgAnyOf),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutId      (OutId),
    .ClearStats (ClearStats),
    .SeenCount  (SeenCount),
    .MatchCount (MatchCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_seen  = 0;
    m_match = 0;
    m_set   = DEF_MUST_SET;
    m_clr   = DEF_MUST_CLR;
    m_any   = DEF_ANY_OF;
  endtask

  // Outputs are compared at the falling edge, then the model steps for the coming rising edge.
  always @(negedge Clk) begin
    if (!ResetN) begin
      model_reset();
    end else begin
      check("out_valid", OutValid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("out_id", OutId, exp_q[0]);
      check("in_ready", InReady, exp_q.size() < DEPTH);
      check("seen", SeenCount, m_seen);
      check("match", MatchCount, m_match);
      if (OutValid && OutReady && exp_q.size() != 0) begin
        out_log.push_back(int'(OutId));
        void'(exp_q.pop_front());
      end
      if (InValid && InReady) begin
        if (cat_match(16'(InAttr), 16'(m_set), 16'(m_clr), 16'(m_any))) begin
          exp_q.push_back(int'(InId));
          if (!ClearStats && m_match != CNT_MAX) m_match++;
        end
        if (!ClearStats && m_seen != CNT_MAX) m_seen++;
      end
      if (ClearStats) begin
        m_seen  = 0;
        m_match = 0;
      end
      if (CfgLoad) begin
        m_set = CfgMustSet;
        m_clr = CfgMustClr;
        m_any = CfgAnyOf;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] id, input logic [3:0] attr);
    logic acc;
    int   n;
    InValid = 1'b1;
    InId    = id;
    InAttr  = attr;
    n       = 0;
    do begin
      acc = InReady;
      tick();
      n++;
    end while (!acc && n < 50);
    check("send_accept", acc, 1'b1);
    InValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    OutReady = 1'b1;
    while ((OutValid || exp_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check("drain_empty", OutValid, 1'b0);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, out_log.size(), exp_log.size());
    foreach (exp_log[i]) begin
      if (i < out_log.size()) check(tag, out_log[i], exp_log[i]);
    end
    out_log.delete();
    exp_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ResetN = 1'b0; InValid = 1'b0; InId = '0; InAttr = '0;
    CfgLoad = 1'b0; CfgMustSet = '0; CfgMustClr = '0; CfgAnyOf = '0;
    OutReady = 1'b0; ClearStats = 1'b0;
    #3;
    check("rst_out_valid", OutValid, 1'b0);
    check("rst_out_id", OutId, 8'd0);
    check("rst_seen", SeenCount, 0);
    check("rst_match", MatchCount, 0);
    repeat (2) @(posedge Clk);
    #2 ResetN = 1'b1;
    tick();
    check("rst_in_ready", InReady, 1'b1);

    // Default masks: only the sterilized black-or-red female matches.
    OutReady = 1'b1;
    send(8'd1, 4'b1001);
    send(8'd2, 4'b0100);
    send(8'd3, 4'b0111);
    drain();
    check("t1_seen", SeenCount, 3);
    check("t1_match", MatchCount, 1);
    exp_log = '{3};
    check_log("t1_order");

    // Back-pressure: fifth ID held off until the consumer drains.
    ClearStats = 1'b1; tick(); ClearStats = 1'b0;
    OutReady = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(10 + i), 4'b0101);
    check("t2_full_ready", InReady, 1'b0);
    InValid = 1'b1; InId = 8'd14; InAttr = 4'b0101;
    tick(); tick();
    check("t2_held_ready", InReady, 1'b0);
    check("t2_held_valid", OutValid, 1'b1);
    OutReady = 1'b1;
    send(8'd14, 4'b0101);
    drain();
    check("t2_recover", InReady, 1'b1);
    exp_log = '{10, 11, 12, 13, 14};
    check_log("t2_order");

    // Simultaneous push and pop across pointer wrap with two entries held.
    OutReady = 1'b0;
    send(8'd20, 4'b0101);
    send(8'd21, 4'b0101);
    OutReady = 1'b1;
    InValid = 1'b1; InAttr = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      InId = 8'(22 + i);
      check("t3_ready", InReady, 1'b1);
      check("t3_valid", OutValid, 1'b1);
      tick();
    end
    InValid = 1'b0; OutReady = 1'b0;
    send(8'd42, 4'b0101);
    send(8'd43, 4'b0101);
    check("t3_full_at_4", InReady, 1'b0);
    drain();
    exp_log = '{20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 42, 43};
    check_log("t3_order");

    // Mask reload: the record in the load cycle still sees the old rule.
    OutReady = 1'b1;
    CfgMustSet = '0; CfgMustClr = '0; CfgAnyOf = '0; CfgLoad = 1'b1;
    InValid = 1'b1; InId = 8'd50; InAttr = 4'b1000;
    check("t4_ready", InReady, 1'b1);
    tick();
    CfgLoad = 1'b0; InValid = 1'b0;
    send(8'd51, 4'b1000);
    drain();
    exp_log = '{51};
    check_log("t4_order");

    // Saturation and clear-over-increment priority.
    ClearStats = 1'b1; tick(); ClearStats = 1'b0;
    for (int i = 0; i < 9; i++) send(8'(80 + i), 4'b0000);
    check("t5_seen_sat", SeenCount, 7);
    check("t5_match_sat", MatchCount, 7);
    ClearStats = 1'b1; InValid = 1'b1; InId = 8'd90; InAttr = 4'b0000;
    tick();
    ClearStats = 1'b0; InValid = 1'b0;
    check("t5_seen_clr", SeenCount, 0);
    check("t5_match_clr", MatchCount, 0);
    drain();
    out_log.delete();

    // Asynchronous reset with IDs buffered.
    OutReady = 1'b0;
    send(8'd60, 4'b0000);
    send(8'd61, 4'b0000);
    send(8'd62, 4'b0000);
    #2 ResetN = 1'b0;
    model_reset();
    #1;
    check("t6_valid", OutValid, 1'b0);
    check("t6_id", OutId, 8'd0);
    check("t6_seen", SeenCount, 0);
    check("t6_match", MatchCount, 0);
    @(posedge Clk);
    #2 ResetN = 1'b1;
    tick();
    check("t6_no_stale", OutValid, 1'b0);
    check("t6_ready", InReady, 1'b1);
    OutReady = 1'b1;
    send(8'd70, 4'b1000);
    send(8'd71, 4'b0101);
    drain();
    exp_log = '{71};
    check_log("t6_order");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
